regfile_sequencer: RTL

Command-driven initiator for the 4-entry × 32-bit register file: accepts a three-operand ALU command, drives the two read-port selects, captures both operands, computes the result and writes it back through the file's single write port. Sits between the control/test-stimulus logic and the register file. It replaces hand-sequenced ReadReg/WriteReg/RegWrite stimulus with a checked, fixed-latency protocol.

---
 rtl/regfile_sequencer_pkg.sv | 22 ++
 rtl/regseq_alu.sv | 33 +++
 rtl/regfile_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/regfile_sequencer_pkg.sv
// Shared types and defaults for the register-file sequencer.
// Op-code and state encodings live here so the datapath can reuse them.
package regfile_sequencer_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } aluOp_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_EXEC  = 2'b10,
    S_WRITE = 2'b11
  } seqState_e;

endpackage

// File: rtl/regseq_alu.sv
// Combinational ALU: ADD/SUB/AND/OR with signed overflow.
// Overflow is meaningful for ADD/SUB only and reads 0 otherwise.
module regseq_alu
  import regfile_sequencer_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  aluOp_e       op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         ovf
);

  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (op)
      OP_ADD: begin
        res = a + b;
        ovf = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      OP_SUB: begin
        res = a - b;
        ovf = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Fixed-latency read/exec/write sequencer for a 2R1W register file.
// Define OVF_TRAP_EN to suppress writes of signed-overflowing ADD/SUB.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  output logic [ADDR_W-1:0] ReadReg1,
  output logic [ADDR_W-1:0] ReadReg2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  seqState_e         state;
  aluOp_e            opReg;
  logic [ADDR_W-1:0] rdReg;
  logic [DATA_W-1:0] aluRes;
  logic              aluOvf;

  regseq_alu #(.W(DATA_W)) uAlu (
    .op (opReg),
    .a  (ReadData1),
    .b  (ReadData2),
    .res(aluRes),
    .ovf(aluOvf)
  );

`ifndef OVF_TRAP_EN
  logic unusedOvf;
  assign unusedOvf = aluOvf;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      opReg     <= OP_ADD;
      rdReg     <= '0;
      cmd_ready <= 1'b1;
      ReadReg1  <= '0;
      ReadReg2  <= '0;
      WriteReg  <= '0;
      WriteData <= '0;
      RegWrite  <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else begin
      RegWrite <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            opReg     <= aluOp_e'(cmd_op);
            rdReg     <= cmd_rd;
            ReadReg1  <= cmd_rs1;
            ReadReg2  <= cmd_rs2;
            cmd_ready <= 1'b0;
            state     <= S_READ;
          end
        end
        S_READ: state <= S_EXEC;
        S_EXEC: begin
          // Operands are consumed here, before any write-back.
          WriteReg  <= rdReg;
          WriteData <= aluRes;
          result    <= aluRes;
          done      <= 1'b1;
`ifdef OVF_TRAP_EN
          ovf       <= aluOvf;
          RegWrite  <= !aluOvf;
`else
          ovf       <= 1'b0;
          RegWrite  <= 1'b1;
`endif
          state     <= S_WRITE;
        end
        S_WRITE: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
